// File: rtl/fifo_pkg.sv
// Shared definitions for the syncfifo read path: reader states and default sizing.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } rd_state_t;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_BURST_LEN = 16;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus outgoing valid/ready stream of the burst reader.
interface fifo_burst_reader_if
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_data_out;
    logic             fifo_empty;
    logic             fifo_prog_empty;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
        output fifo_rd_en, m_valid, m_data, m_last,
        input  fifo_data_out, fifo_empty, fifo_prog_empty, m_ready
    );

    modport slave (
        input  fifo_rd_en, m_valid, m_data, m_last,
        output fifo_data_out, fifo_empty, fifo_prog_empty, m_ready
    );

endinterface

// File: rtl/skid_buf2.sv
// Two-entry in-order buffer; entry 0 is the head presented downstream.
module skid_buf2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ    <= '0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) entry0 <= push_data;
                    else             entry1 <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    occ    <= occ - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; new word lands behind whatever remains
                    if (occ == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (occ != 2'd0);
    assign data  = entry0;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains fixed-length bursts from syncfifo into a valid/ready stream with m_last framing.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN,
    parameter int unsigned CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    fifo_burst_reader_if.master bus,
    output logic                busy,
    output logic [CNT_W-1:0]    rd_cnt
);

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);

    rd_state_t        state;
    rd_state_t        state_nxt;
    logic [CNT_W-1:0] out_cnt;
    logic             inflight;
    logic             rd_en;
    logic             pop;
    logic             last_beat;
    logic             credit_ok;
    logic [2:0]       credit_used;
    logic [1:0]       occ;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    skid_buf2 #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (bus.fifo_data_out),
        .pop       (pop),
        .valid     (skid_valid),
        .data      (skid_data),
        .occ       (occ)
    );

    assign pop       = skid_valid && bus.m_ready;
    assign last_beat = (out_cnt == LAST_IDX);

    // A read is issued only if its word still has a skid slot when it lands next cycle.
    assign credit_used = 3'(occ) + 3'(inflight);
    assign credit_ok   = credit_used < (3'd2 + 3'(pop));

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (en && !bus.fifo_prog_empty) state_nxt = FETCH;
            end
            FETCH: begin
                rd_en = !bus.fifo_empty && (rd_cnt < BURST_CNT) && credit_ok;
                if (rd_en && (rd_cnt == LAST_IDX)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && last_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_cnt   <= '0;
            out_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= rd_en;
            if (pop && last_beat) begin
                rd_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (rd_en) rd_cnt  <= rd_cnt + CNT_W'(1);
                if (pop)   out_cnt <= out_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = skid_valid;
    assign bus.m_data     = skid_data;
    assign bus.m_last     = skid_valid && last_beat;
    assign busy           = (state != IDLE);

endmodule
